// File: rtl/sram_arbiter_if.sv
// Bus bundle between the 6502 core, the DMA requester and the external SRAM pins.
`timescale 1ns/1ps
interface sram_arbiter_if;
  // CPU side
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  // DMA side
  logic        dma_valid;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ready;
  logic [7:0]  dma_rdata;
  // SRAM pins
  logic [15:0] sram_addr;
  logic [7:0]  sram_dout;
  logic        sram_drive;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [7:0]  sram_din;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_rdy,
    input  dma_valid, dma_we, dma_addr, dma_wdata,
    output dma_ready, dma_rdata,
    output sram_addr, sram_dout, sram_drive, sram_oe_n, sram_we_n,
    input  sram_din
  );

  // Requester / SRAM-model side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_rdy,
    output dma_valid, dma_we, dma_addr, dma_wdata,
    input  dma_ready, dma_rdata,
    input  sram_addr, sram_dout, sram_drive, sram_oe_n, sram_we_n,
    output sram_din
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares the external async SRAM between the 6502 core (priority) and one DMA
// requester. The CPU is stalled via RDY only during DMA ops and stretched writes;
// a starvation counter forces a DMA slot after MAX_CPU_RUN contended CPU grants.
`timescale 1ns/1ps
module sram_arbiter #(
  parameter int unsigned WR_CYCLES   = 2,
  parameter int unsigned MAX_CPU_RUN = 8
) (
  input logic           clk,
  input logic           reset,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCpuWr, StDmaRd, StDmaWr} state_e;

  localparam logic [2:0] WrLast    = 3'(WR_CYCLES - 1);
  localparam logic [7:0] StarveMax = 8'(MAX_CPU_RUN);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] starve_q, starve_d;
  logic       dma_ready_q, dma_ready_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d;
  logic [7:0] dma_rdata_q, dma_rdata_d;
  logic       dma_pend;

  // A request whose ready pulse is showing has been consumed; it must not win again.
  assign dma_pend = bus.dma_valid & ~dma_ready_q;

  // State, counters and read-data registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      starve_q    <= 8'd0;
      dma_ready_q <= 1'b0;
      cpu_rdata_q <= 8'd0;
      dma_rdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      dma_ready_q <= dma_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Arbitration, next state and SRAM pin drive.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    starve_d       = starve_q;
    dma_ready_d    = 1'b0;
    cpu_rdata_d    = cpu_rdata_q;
    dma_rdata_d    = dma_rdata_q;
    bus.sram_addr  = 16'd0;
    bus.sram_dout  = 8'd0;
    bus.sram_drive = 1'b0;
    bus.sram_oe_n  = 1'b1;
    bus.sram_we_n  = 1'b1;
    bus.cpu_rdy    = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.cpu_rdy = 1'b1;
        // Reset gates grants so the pins are released the instant reset asserts.
        if (reset) begin
          if (dma_pend && (!bus.cpu_req || starve_q == StarveMax)) begin
            starve_d      = 8'd0;
            bus.cpu_rdy   = 1'b0;
            bus.sram_addr = bus.dma_addr;
            if (bus.dma_we) begin
              bus.sram_dout  = bus.dma_wdata;
              bus.sram_drive = 1'b1;
              bus.sram_we_n  = 1'b0;
              if (WR_CYCLES == 1) begin
                dma_ready_d = 1'b1;
              end else begin
                state_d = StDmaWr;
                cnt_d   = 3'd1;
              end
            end else begin
              bus.sram_oe_n = 1'b0;
              state_d       = StDmaRd;
            end
          end else begin
            if (!dma_pend) begin
              starve_d = 8'd0;
            end else if (bus.cpu_req && starve_q != StarveMax) begin
              starve_d = starve_q + 8'd1;
            end
            if (bus.cpu_req) begin
              bus.sram_addr = bus.cpu_addr;
              if (bus.cpu_we) begin
                bus.sram_dout  = bus.cpu_wdata;
                bus.sram_drive = 1'b1;
                bus.sram_we_n  = 1'b0;
                if (WR_CYCLES != 1) begin
                  bus.cpu_rdy = 1'b0;
                  state_d     = StCpuWr;
                  cnt_d       = 3'd1;
                end
              end else begin
                bus.sram_oe_n = 1'b0;
                cpu_rdata_d   = bus.sram_din;
              end
            end
          end
        end
      end

      // Core holds AB/DO while RDY is low, so the live bus is still the write target.
      StCpuWr: begin
        bus.sram_addr  = bus.cpu_addr;
        bus.sram_dout  = bus.cpu_wdata;
        bus.sram_drive = 1'b1;
        bus.sram_we_n  = 1'b0;
        if (cnt_q == WrLast) begin
          bus.cpu_rdy = 1'b1;
          cnt_d       = 3'd0;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      StDmaRd: begin
        bus.sram_addr = bus.dma_addr;
        bus.sram_oe_n = 1'b0;
        dma_rdata_d   = bus.sram_din;
        dma_ready_d   = 1'b1;
        state_d       = StIdle;
      end

      StDmaWr: begin
        bus.sram_addr  = bus.dma_addr;
        bus.sram_dout  = bus.dma_wdata;
        bus.sram_drive = 1'b1;
        bus.sram_we_n  = 1'b0;
        if (cnt_q == WrLast) begin
          dma_ready_d = 1'b1;
          cnt_d       = 3'd0;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_ready = dma_ready_q;
  assign bus.dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a 4 KiB SRAM model (WR_CYCLES=2, MAX_CPU_RUN=8).
`timescale 1ns/1ps
module tb_sram_arbiter;
  logic clk;
  logic reset;
  logic preload;
  int   n_checks;
  int   n_fail;
  logic [7:0] mem [0:4095];

  sram_arbiter_if bus ();

  sram_arbiter #(.WR_CYCLES(2), .MAX_CPU_RUN(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model: combinational read, write sampled while WE_n is low.
  assign bus.sram_din = mem[bus.sram_addr[11:0]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      mem[12'h123] <= 8'h5A;
      mem[12'h200] <= 8'h3C;
    end else if (!bus.sram_we_n) begin
      mem[bus.sram_addr[11:0]] <= bus.sram_dout;
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_checks++; if (bus.cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_rdy: got %b want 1", bus.cpu_rdy); end
    n_checks++; if (bus.dma_ready !== 1'b0) begin n_fail++; $display("FAIL rst_dma_ready: got %b want 0", bus.dma_ready); end
    n_checks++; if (bus.sram_we_n !== 1'b1) begin n_fail++; $display("FAIL rst_we_n: got %b want 1", bus.sram_we_n); end
    n_checks++; if (bus.sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL rst_oe_n: got %b want 1", bus.sram_oe_n); end
    n_checks++; if (bus.sram_drive !== 1'b0) begin n_fail++; $display("FAIL rst_drive: got %b want 0", bus.sram_drive); end
    n_checks++; if (bus.sram_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h want 0000", bus.sram_addr); end
    n_checks++; if (bus.cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_cpu_rdata: got %h want 00", bus.cpu_rdata); end
    n_checks++; if (bus.dma_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_dma_rdata: got %h want 00", bus.dma_rdata); end
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b1;
    preload = 1'b0;
  endtask

  task automatic test_cpu_read();
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0123;
    #1;
    n_checks++; if (bus.sram_oe_n !== 1'b0) begin n_fail++; $display("FAIL rd_oe_n: got %b want 0", bus.sram_oe_n); end
    n_checks++; if (bus.sram_addr !== 16'h0123) begin n_fail++; $display("FAIL rd_addr: got %h want 0123", bus.sram_addr); end
    n_checks++; if (bus.cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL rd_rdy: got %b want 1", bus.cpu_rdy); end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    #1;
    n_checks++; if (bus.cpu_rdata !== 8'h5A) begin n_fail++; $display("FAIL rd_data: got %h want 5a", bus.cpu_rdata); end
    n_checks++; if (bus.sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL rd_oe_release: got %b want 1", bus.sram_oe_n); end
  endtask

  task automatic test_cpu_write();
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 8'hA5;
    #1;
    n_checks++; if (bus.sram_we_n !== 1'b0) begin n_fail++; $display("FAIL wr_we_n_c1: got %b want 0", bus.sram_we_n); end
    n_checks++; if (bus.sram_drive !== 1'b1) begin n_fail++; $display("FAIL wr_drive_c1: got %b want 1", bus.sram_drive); end
    n_checks++; if (bus.sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL wr_oe_n_c1: got %b want 1", bus.sram_oe_n); end
    n_checks++; if (bus.cpu_rdy !== 1'b0) begin n_fail++; $display("FAIL wr_rdy_c1: got %b want 0", bus.cpu_rdy); end
    @(posedge clk); #2;
    n_checks++; if (bus.sram_we_n !== 1'b0) begin n_fail++; $display("FAIL wr_we_n_c2: got %b want 0", bus.sram_we_n); end
    n_checks++; if (bus.sram_addr !== 16'h0010) begin n_fail++; $display("FAIL wr_addr_c2: got %h want 0010", bus.sram_addr); end
    n_checks++; if (bus.cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL wr_rdy_c2: got %b want 1", bus.cpu_rdy); end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    #1;
    n_checks++; if (bus.sram_we_n !== 1'b1) begin n_fail++; $display("FAIL wr_we_n_c3: got %b want 1", bus.sram_we_n); end
    n_checks++; if (bus.sram_drive !== 1'b0) begin n_fail++; $display("FAIL wr_drive_c3: got %b want 0", bus.sram_drive); end
    n_checks++; if (mem[12'h010] !== 8'hA5) begin n_fail++; $display("FAIL wr_mem: got %h want a5", mem[12'h010]); end
  endtask

  task automatic test_dma_read();
    @(posedge clk); #1;
    bus.dma_valid = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0200;
    #1;
    n_checks++; if (bus.sram_oe_n !== 1'b0) begin n_fail++; $display("FAIL drd_oe_n_c1: got %b want 0", bus.sram_oe_n); end
    n_checks++; if (bus.sram_addr !== 16'h0200) begin n_fail++; $display("FAIL drd_addr_c1: got %h want 0200", bus.sram_addr); end
    n_checks++; if (bus.cpu_rdy !== 1'b0) begin n_fail++; $display("FAIL drd_rdy_c1: got %b want 0", bus.cpu_rdy); end
    @(posedge clk); #2;
    n_checks++; if (bus.sram_oe_n !== 1'b0) begin n_fail++; $display("FAIL drd_oe_n_c2: got %b want 0", bus.sram_oe_n); end
    n_checks++; if (bus.dma_ready !== 1'b0) begin n_fail++; $display("FAIL drd_ready_c2: got %b want 0", bus.dma_ready); end
    @(posedge clk); #2;
    n_checks++; if (bus.dma_ready !== 1'b1) begin n_fail++; $display("FAIL drd_ready_c3: got %b want 1", bus.dma_ready); end
    n_checks++; if (bus.dma_rdata !== 8'h3C) begin n_fail++; $display("FAIL drd_data: got %h want 3c", bus.dma_rdata); end
    n_checks++; if (bus.sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL drd_no_regrant: got %b want 1", bus.sram_oe_n); end
    @(posedge clk); #1;
    bus.dma_valid = 1'b0;
    #1;
    n_checks++; if (bus.dma_ready !== 1'b0) begin n_fail++; $display("FAIL drd_pulse_width: got %b want 0", bus.dma_ready); end
  endtask

  task automatic test_starvation();
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0123;
    bus.dma_valid = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0200;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++; if (bus.cpu_rdy !== 1'b1 || bus.sram_addr !== 16'h0123) begin
        n_fail++; $display("FAIL starve_cpu_grant%0d: got rdy=%b addr=%h want rdy=1 addr=0123", i, bus.cpu_rdy, bus.sram_addr);
      end
      @(posedge clk); #1;
    end
    #1;
    n_checks++; if (bus.cpu_rdy !== 1'b0) begin n_fail++; $display("FAIL starve_dma_rdy: got %b want 0", bus.cpu_rdy); end
    n_checks++; if (bus.sram_addr !== 16'h0200) begin n_fail++; $display("FAIL starve_dma_addr: got %h want 0200", bus.sram_addr); end
    @(posedge clk); #2;
    n_checks++; if (bus.cpu_rdy !== 1'b0) begin n_fail++; $display("FAIL starve_dma_rdy2: got %b want 0", bus.cpu_rdy); end
    @(posedge clk); #2;
    n_checks++; if (bus.dma_ready !== 1'b1) begin n_fail++; $display("FAIL starve_ready: got %b want 1", bus.dma_ready); end
    n_checks++; if (bus.cpu_rdy !== 1'b1 || bus.sram_addr !== 16'h0123) begin
      n_fail++; $display("FAIL starve_cpu_back: got rdy=%b addr=%h want rdy=1 addr=0123", bus.cpu_rdy, bus.sram_addr);
    end
    @(posedge clk); #1;
    bus.dma_valid = 1'b0; bus.cpu_req = 1'b0;
  endtask

  task automatic test_dma_write_in_burst();
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0123;
    bus.dma_valid = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'h0300; bus.dma_wdata = 8'h77;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++; if (bus.cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL burst_cpu_grant%0d: got %b want 1", i, bus.cpu_rdy); end
      @(posedge clk); #1;
    end
    #1;
    n_checks++; if (bus.sram_we_n !== 1'b0 || bus.sram_drive !== 1'b1 || bus.sram_addr !== 16'h0300) begin
      n_fail++; $display("FAIL dwr_c1: got we_n=%b drive=%b addr=%h want 0 1 0300", bus.sram_we_n, bus.sram_drive, bus.sram_addr);
    end
    n_checks++; if (bus.cpu_rdy !== 1'b0) begin n_fail++; $display("FAIL dwr_rdy_c1: got %b want 0", bus.cpu_rdy); end
    @(posedge clk); #2;
    n_checks++; if (bus.sram_we_n !== 1'b0 || bus.cpu_rdy !== 1'b0 || bus.dma_ready !== 1'b0) begin
      n_fail++; $display("FAIL dwr_c2: got we_n=%b rdy=%b ready=%b want 0 0 0", bus.sram_we_n, bus.cpu_rdy, bus.dma_ready);
    end
    @(posedge clk); #2;
    n_checks++; if (bus.dma_ready !== 1'b1 || bus.sram_we_n !== 1'b1) begin
      n_fail++; $display("FAIL dwr_c3: got ready=%b we_n=%b want 1 1", bus.dma_ready, bus.sram_we_n);
    end
    n_checks++; if (bus.cpu_rdy !== 1'b1 || bus.sram_oe_n !== 1'b0) begin
      n_fail++; $display("FAIL dwr_cpu_retry: got rdy=%b oe_n=%b want 1 0", bus.cpu_rdy, bus.sram_oe_n);
    end
    n_checks++; if (mem[12'h300] !== 8'h77) begin n_fail++; $display("FAIL dwr_mem: got %h want 77", mem[12'h300]); end
    @(posedge clk); #1;
    bus.dma_valid = 1'b0; bus.cpu_req = 1'b0; bus.dma_we = 1'b0;
  endtask

  task automatic test_reset_mid_dma_wr();
    @(posedge clk); #1;
    bus.dma_valid = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'h0400; bus.dma_wdata = 8'h11;
    @(posedge clk); #1;
    n_checks++; if (bus.sram_we_n !== 1'b0) begin n_fail++; $display("FAIL rstw_in_pulse: got %b want 0", bus.sram_we_n); end
    reset = 1'b0;
    #1;
    n_checks++; if (bus.sram_we_n !== 1'b1 || bus.sram_drive !== 1'b0) begin
      n_fail++; $display("FAIL rstw_release: got we_n=%b drive=%b want 1 0", bus.sram_we_n, bus.sram_drive);
    end
    @(posedge clk); #1;
    reset = 1'b1; bus.dma_valid = 1'b0; bus.dma_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (bus.dma_ready !== 1'b0) begin n_fail++; $display("FAIL rstw_no_ready%0d: got %b want 0", i, bus.dma_ready); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    preload  = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'h00;
    bus.dma_valid = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 16'h0000; bus.dma_wdata = 8'h00;
    #2;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_dma_read();
    test_starvation();
    test_dma_write_in_burst();
    test_reset_mid_dma_wr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
